i2c_target_rx: RTL and testbench

- I2C target (slave) receiver directly downstream of the I2C bus master.
- Watches SCL/SDA and detects START/STOP.
- Shifts in the 7-bit address plus R/W bit; ACKs on address match with write; receives one or more data bytes, ACKing each.
- Presents each received byte to local logic with a one-cycle valid strobe. It is the on-chip/bench counterpart that makes master transfers end in "success".

---
 rtl/i2c_pkg.sv | 14 +
 rtl/i2c_line_sync.sv | 29 ++
 rtl/i2c_target_rx.sv | 121 ++++++++++++
 tb/tb_i2c_target_rx.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: field widths and the target receiver state set.
package i2c_pkg;
  localparam int unsigned I2C_ADDR_W = 7;
  localparam int unsigned I2C_BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    DATA,
    DATA_ACK,
    IGNORE
  } rx_state_e;
endpackage

// File: rtl/i2c_line_sync.sv
// Multi-stage synchronizer plus rise/fall detector for one I2C line.
// Every register presets to 1 so that a reset leaves the bus looking idle.
module i2c_line_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic line_i,
  output logic line_o,
  output logic rise_o,
  output logic fall_o
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], line_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign line_o = sync_q[SYNC_STAGES-1];
  assign rise_o = line_o & ~prev_q;
  assign fall_o = ~line_o & prev_q;
endmodule

// File: rtl/i2c_target_rx.sv
// I2C write-only target: detects START/STOP, matches the address, ACKs
// each byte and strobes every completed data byte to local logic.
module i2c_target_rx
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] OWN_ADDR    = 7'h42,
  parameter int unsigned           SYNC_STAGES = 2
) (
  input  logic                  mclk,
  input  logic                  rst,
  input  logic                  scl_in,
  input  logic                  sda_in,
  output logic                  sda_drive_low,
  output logic [I2C_BYTE_W-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  addr_hit,
  output logic                  busy
);
  logic scl_s, scl_rise, scl_fall;
  logic sda_s, sda_rise, sda_fall;
  logic start_cond, stop_cond;

  rx_state_e             state_q;
  logic [2:0]            cnt_q;
  logic [I2C_BYTE_W-1:0] shift_q, shift_d;
  logic                  drive_q, valid_q, hit_q, busy_q;
  logic [I2C_BYTE_W-1:0] data_q;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
    .clk_i (mclk),
    .rst_i (rst),
    .line_i(scl_in),
    .line_o(scl_s),
    .rise_o(scl_rise),
    .fall_o(scl_fall)
  );

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
    .clk_i (mclk),
    .rst_i (rst),
    .line_i(sda_in),
    .line_o(sda_s),
    .rise_o(sda_rise),
    .fall_o(sda_fall)
  );

  assign start_cond = sda_fall & scl_s;
  assign stop_cond  = sda_rise & scl_s;
  assign shift_d    = {shift_q[I2C_BYTE_W-2:0], sda_s};

  always_ff @(posedge mclk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      drive_q <= 1'b0;
      valid_q <= 1'b0;
      hit_q   <= 1'b0;
      busy_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= 1'b0;
      if (start_cond) begin
        state_q <= ADDR;
        cnt_q   <= '0;
        drive_q <= 1'b0;
        hit_q   <= 1'b0;
        busy_q  <= 1'b1;
      end else if (stop_cond) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        drive_q <= 1'b0;
        hit_q   <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          ADDR: begin
            if (scl_rise) begin
              shift_q <= shift_d;
              cnt_q   <= cnt_q + 3'd1;
              if (cnt_q == 3'd7)
                state_q <= (shift_d[7:1] == OWN_ADDR && !shift_d[0]) ? ADDR_ACK : IGNORE;
            end
          end
          DATA: begin
            if (scl_rise) begin
              shift_q <= shift_d;
              cnt_q   <= cnt_q + 3'd1;
              if (cnt_q == 3'd7) begin
                data_q  <= shift_d;
                valid_q <= 1'b1;
                state_q <= DATA_ACK;
              end
            end
          end
          // First SCL fall after the byte pulls SDA low, the next one releases it.
          ADDR_ACK, DATA_ACK: begin
            if (scl_fall) begin
              if (!drive_q) begin
                drive_q <= 1'b1;
                if (state_q == ADDR_ACK) hit_q <= 1'b1;
              end else begin
                drive_q <= 1'b0;
                state_q <= DATA;
                cnt_q   <= '0;
              end
            end
          end
          IDLE, IGNORE: ;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign sda_drive_low = drive_q;
  assign rx_data       = data_q;
  assign rx_valid      = valid_q;
  assign addr_hit      = hit_q;
  assign busy          = busy_q;
endmodule

// File: tb/tb_i2c_target_rx.sv
// Bit-banged I2C master driving the target, checked against a transaction-level model.
module tb_i2c_target_rx;
  localparam int unsigned SYNC = 2;
  localparam int unsigned Q    = 8;
  localparam logic [6:0]  OWN  = 7'h42;

  logic       mclk = 1'b0;
  logic       rst, scl_m, sda_m, sda_bus;
  logic       sda_drive_low, rx_valid, addr_hit, busy;
  logic [7:0] rx_data;

  int         checks = 0, errors = 0, valid_cnt = 0;
  logic [7:0] exp_q[$];
  bit         may_drive = 0;

  assign sda_bus = sda_m & ~sda_drive_low;

  i2c_target_rx #(.OWN_ADDR(OWN), .SYNC_STAGES(SYNC)) dut (
    .mclk         (mclk),
    .rst          (rst),
    .scl_in       (scl_m),
    .sda_in       (sda_bus),
    .sda_drive_low(sda_drive_low),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .addr_hit     (addr_hit),
    .busy         (busy)
  );

  always #5 mclk = ~mclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_q();
    repeat (Q) @(negedge mclk);
  endtask

  // One data bit; optionally times how long after the SCL fall the target pulls SDA.
  task automatic put_bit(input logic b, input bit meas, output int lat);
    sda_m = b; wait_q();
    scl_m = 1'b1; wait_q(); wait_q();
    scl_m = 1'b0;
    lat = 0;
    for (int k = 1; k <= Q; k++) begin
      @(negedge mclk);
      if (meas && lat == 0 && sda_drive_low) lat = k;
    end
  endtask

  task automatic ack_bit(output logic ack);
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    ack = (sda_bus == 1'b0);
    wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic send_byte(input logic [7:0] b, input int nbits, input bit exp_ack);
    int   lat;
    logic ack;
    for (int i = 0; i < nbits; i++) put_bit(b[7-i], (i == 7) && exp_ack, lat);
    if (nbits == 8) begin
      if (exp_ack) chk("ack_latency", lat, SYNC + 1);
      ack_bit(ack);
      chk("ack", ack, exp_ack);
    end
  endtask

  task automatic start_cond();
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b0; wait_q();
    chk("busy_after_start", busy, 1);
    chk("hit_after_start", addr_hit, 0);
  endtask

  task automatic stop_cond(input bit check_lat);
    int lat = 0;
    sda_m = 1'b0; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b1;
    for (int k = 1; k <= Q; k++) begin
      @(negedge mclk);
      if (lat == 0 && !busy) lat = k;
    end
    if (check_lat) chk("stop_latency", lat, SYNC + 1);
    chk("busy_after_stop", busy, 0);
    chk("hit_after_stop", addr_hit, 0);
    chk("drive_after_stop", sda_drive_low, 0);
    may_drive = 0;
  endtask

  // Model: only a matching write address is ACKed, and only its complete bytes arrive.
  task automatic txn(input logic [6:0] addr, input logic rw, input int n,
                     input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                     input int last_bits, input bit do_stop);
    bit         match = (addr == OWN) && !rw;
    logic [7:0] d;
    int         nb;
    may_drive = match;
    start_cond();
    send_byte({addr, rw}, 8, match);
    chk("addr_hit", addr_hit, match);
    for (int i = 0; i < n; i++) begin
      d  = (i == 0) ? d0 : (i == 1) ? d1 : d2;
      nb = (i == n - 1) ? last_bits : 8;
      if (match && nb == 8) exp_q.push_back(d);
      send_byte(d, nb, match && nb == 8);
    end
    if (do_stop) stop_cond(1);
  endtask

  initial begin
    logic [7:0] e;
    bit         stop_flag;
    int         lat;
    rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
    repeat (3) @(negedge mclk);
    chk("rst_drive", sda_drive_low, 0);
    chk("rst_data", rx_data, 8'h00);
    chk("rst_valid", rx_valid, 0);
    chk("rst_hit", addr_hit, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;

    fork
      forever begin
        @(negedge mclk);
        if (!rst) begin
          if (rx_valid) begin
            valid_cnt++;
            chk("valid_needs_hit", addr_hit, 1);
            if (exp_q.size() == 0) chk("unexpected_valid", rx_data, 32'hFFFF_FFFF);
            else begin
              e = exp_q.pop_front();
              chk("rx_data", rx_data, e);
            end
          end
          if (!may_drive) chk("sda_not_driven", sda_drive_low, 0);
        end
      end
    join_none
    repeat (4) @(negedge mclk);

    txn(OWN, 1'b0, 1, 8'hA5, 8'h00, 8'h00, 8, 1);
    chk("a5_count", valid_cnt, 1);
    chk("a5_data", rx_data, 8'hA5);

    txn(7'h13, 1'b0, 1, 8'h3C, 8'h00, 8'h00, 8, 1);
    chk("mismatch_count", valid_cnt, 1);

    txn(OWN, 1'b1, 1, 8'h55, 8'h00, 8'h00, 8, 1);
    chk("read_count", valid_cnt, 1);

    txn(OWN, 1'b0, 3, 8'h01, 8'hFF, 8'h80, 8, 1);
    chk("multi_count", valid_cnt, 4);
    chk("multi_last", rx_data, 8'h80);

    txn(OWN, 1'b0, 1, 8'hF0, 8'h00, 8'h00, 4, 1);
    chk("trunc_count", valid_cnt, 4);
    txn(OWN, 1'b0, 1, 8'h5A, 8'h00, 8'h00, 8, 1);
    chk("after_trunc_count", valid_cnt, 5);
    chk("after_trunc_data", rx_data, 8'h5A);

    // Reset while the target holds SDA low for the address ACK.
    may_drive = 1;
    start_cond();
    for (int i = 0; i < 8; i++) put_bit(8'h84 >> (7 - i), i == 7, lat);
    chk("rst_test_latency", lat, SYNC + 1);
    chk("rst_test_driving", sda_drive_low, 1);
    rst = 1'b1;
    @(negedge mclk);
    chk("midrst_drive", sda_drive_low, 0);
    chk("midrst_data", rx_data, 8'h5A == 8'h00 ? 1 : 0);
    chk("midrst_valid", rx_valid, 0);
    chk("midrst_hit", addr_hit, 0);
    chk("midrst_busy", busy, 0);
    rst = 1'b0;
    stop_cond(0);
    txn(OWN, 1'b0, 1, 8'h77, 8'h00, 8'h00, 8, 1);
    chk("post_rst_count", valid_cnt, 6);
    chk("post_rst_data", rx_data, 8'h77);

    for (int t = 0; t < 16; t++) begin
      logic [6:0] a  = ($urandom_range(0, 2) == 0) ? 7'($urandom) : OWN;
      logic       rw = ($urandom_range(0, 4) == 0);
      int         n  = $urandom_range(1, 3);
      int         lb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 8;
      stop_flag = (t == 15) || ($urandom_range(0, 3) != 0);
      txn(a, rw, n, 8'($urandom), 8'($urandom), 8'($urandom), lb, stop_flag);
    end

    repeat (4) @(negedge mclk);
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
